// File: rtl/bytewrite_ram_pkg.sv
// Shared constants for the byte-write simple-dual-port RAM family:
// read-during-write mode encodings and the column bit-offset helper.
package bytewrite_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    // Bit offset of column k inside a data word built from col_width-bit columns.
    function automatic int col_slice(input int k, input int col_width);
        return k * col_width;
    endfunction

endpackage

// File: rtl/bytewrite_ram_col.sv
// One byte-enable column of the SDP RAM: storage array, synchronous read
// register and the write-first same-address bypass for this column.
module bytewrite_ram_col
    import bytewrite_ram_pkg::*;
#(
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RDW_MODE   = RDW_NO_CHANGE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [COL_WIDTH-1:0]  din,
    input  logic                  rd_load,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [COL_WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [COL_WIDTH-1:0] mem_r [DEPTH];
    logic [COL_WIDTH-1:0] rd_word_s;
    logic [COL_WIDTH-1:0] rd_data_r;
    logic                 same_addr_s;

    // Detect a same-address write this cycle for the write-first bypass.
    always_comb begin
        same_addr_s = 1'b0;
        if (wr_en && (write_addr == read_addr)) begin
            same_addr_s = 1'b1;
        end else begin
            same_addr_s = 1'b0;
        end
    end

    // Select stored word or, in write-first mode, the incoming column.
    always_comb begin
        rd_word_s = mem_r[read_addr];
        if ((RDW_MODE == RDW_WRITE_FIRST) && same_addr_s) begin
            rd_word_s = din;
        end else begin
            rd_word_s = mem_r[read_addr];
        end
    end

    // Column storage; deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[write_addr] <= din;
        end
    end

    // Stage-1 read register; holds its value whenever no read is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {COL_WIDTH{1'b0}};
        end else if (rd_load) begin
            rd_data_r <= rd_word_s;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/bytewrite_sdp_ram_cfg.sv
// Parametrised byte-write simple-dual-port RAM with selectable read-during-write
// behaviour, optional output register and a read-valid flag beside the data.
module bytewrite_sdp_ram_cfg
    import bytewrite_ram_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RDW_MODE   = RDW_NO_CHANGE,
    parameter int OUT_REG    = 0,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NUM_COL-1:0]    we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    if ((RDW_MODE > 2) || (RDW_MODE < 0) || (OUT_REG > 1) || (OUT_REG < 0) ||
        (DATA_WIDTH != NUM_COL * COL_WIDTH)) begin : g_bad_param
        $fatal(1, "bytewrite_sdp_ram_cfg: illegal RDW_MODE/OUT_REG/DATA_WIDTH");
    end

    logic [NUM_COL-1:0]    col_we_s;
    logic                  suppress_s;
    logic                  rd_load_s;
    logic [DATA_WIDTH-1:0] s1_data_s;
    logic                  s1_valid_r;

    // In no-change mode any active write, at any address, blocks the read.
    always_comb begin
        col_we_s   = ena ? we : {NUM_COL{1'b0}};
        suppress_s = 1'b0;
        if ((RDW_MODE == RDW_NO_CHANGE) && (|we)) begin
            suppress_s = 1'b1;
        end else begin
            suppress_s = 1'b0;
        end
        rd_load_s = ena && rd_en && !suppress_s;
    end

    for (genvar k = 0; k < NUM_COL; k++) begin : g_col
        bytewrite_ram_col #(
            .COL_WIDTH  (COL_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .RDW_MODE   (RDW_MODE)
        ) u_col (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (col_we_s[k]),
            .write_addr (write_addr),
            .din        (din[col_slice(k, COL_WIDTH) +: COL_WIDTH]),
            .rd_load    (rd_load_s),
            .read_addr  (read_addr),
            .rd_data    (s1_data_s[col_slice(k, COL_WIDTH) +: COL_WIDTH])
        );
    end

    // Stage-1 valid: set by a loaded read, cleared by an idle or suppressed cycle, held on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (ena) begin
            s1_valid_r <= rd_load_s;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    if (OUT_REG == 1) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_data_r;
        logic                  s2_valid_r;

        // Output pipeline stage; advances only with ena so a stall freezes it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_data_r  <= {DATA_WIDTH{1'b0}};
                s2_valid_r <= 1'b0;
            end else if (ena) begin
                s2_data_r  <= s1_data_s;
                s2_valid_r <= s1_valid_r;
            end else begin
                s2_data_r  <= s2_data_r;
                s2_valid_r <= s2_valid_r;
            end
        end

        assign dout       = s2_data_r;
        assign dout_valid = s2_valid_r;
    end else begin : g_no_out_reg
        assign dout       = s1_data_s;
        assign dout_valid = s1_valid_r;
    end

endmodule

// File: tb/tb_bytewrite_sdp_ram_cfg.sv
// Directed and randomised checks of bytewrite_sdp_ram_cfg in all three
// read-during-write modes plus the output-register variant.
module tb_bytewrite_sdp_ram_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [9:0]  write_addr = 10'd0;
    logic [31:0] din = 32'h0;
    logic        rd_en = 1'b0;
    logic [9:0]  read_addr = 10'd0;

    logic [31:0] dout_a [4];
    logic        vld_a  [4];
    logic [31:0] dout0, dout1, dout2, dout3;
    logic        vld0, vld1, vld2, vld3;

    int checks = 0;
    int errors = 0;

    // Behavioural model: shared memory, stage-1 per instance, stage-2 for instance 3.
    logic [31:0] m_mem  [1024];
    logic [31:0] m_s1d  [4];
    logic        m_s1v  [4];
    logic [31:0] m_s2d;
    logic        m_s2v;
    logic [31:0] fill_r [1024];

    always #5 clk = ~clk;

    assign dout_a[0] = dout0; assign dout_a[1] = dout1;
    assign dout_a[2] = dout2; assign dout_a[3] = dout3;
    assign vld_a[0]  = vld0;  assign vld_a[1]  = vld1;
    assign vld_a[2]  = vld2;  assign vld_a[3]  = vld3;

    bytewrite_sdp_ram_cfg #(.RDW_MODE(0)) u_rf (
        .clk(clk), .rst_n(rst_n), .ena(ena), .we(we), .write_addr(write_addr),
        .din(din), .rd_en(rd_en), .read_addr(read_addr), .dout(dout0), .dout_valid(vld0));
    bytewrite_sdp_ram_cfg #(.RDW_MODE(1)) u_wf (
        .clk(clk), .rst_n(rst_n), .ena(ena), .we(we), .write_addr(write_addr),
        .din(din), .rd_en(rd_en), .read_addr(read_addr), .dout(dout1), .dout_valid(vld1));
    bytewrite_sdp_ram_cfg u_nc (
        .clk(clk), .rst_n(rst_n), .ena(ena), .we(we), .write_addr(write_addr),
        .din(din), .rd_en(rd_en), .read_addr(read_addr), .dout(dout2), .dout_valid(vld2));
    bytewrite_sdp_ram_cfg #(.OUT_REG(1)) u_or (
        .clk(clk), .rst_n(rst_n), .ena(ena), .we(we), .write_addr(write_addr),
        .din(din), .rd_en(rd_en), .read_addr(read_addr), .dout(dout3), .dout_valid(vld3));

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1d[i] = 32'h0;
            m_s1v[i] = 1'b0;
        end
        m_s2d = 32'h0;
        m_s2v = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
    task automatic tick(input logic e, input logic [3:0] w, input logic [9:0] wa,
                        input logic [31:0] d, input logic r, input logic [9:0] ra);
        logic [31:0] old_w;
        logic [31:0] merged;
        int          mode;
        ena = e; we = w; write_addr = wa; din = d; rd_en = r; read_addr = ra;
        if (e) begin
            old_w  = m_mem[ra];
            merged = old_w;
            for (int k = 0; k < 4; k++) if (w[k]) merged[k*8 +: 8] = d[k*8 +: 8];
            m_s2d = m_s1d[3];
            m_s2v = m_s1v[3];
            for (int i = 0; i < 4; i++) begin
                mode = (i == 3) ? 2 : i;
                if (r && !((mode == 2) && (w != 4'h0))) begin
                    m_s1d[i] = ((mode == 1) && (wa == ra)) ? merged : old_w;
                    m_s1v[i] = 1'b1;
                end else begin
                    m_s1v[i] = 1'b0;
                end
            end
            for (int k = 0; k < 4; k++) if (w[k]) m_mem[wa][k*8 +: 8] = d[k*8 +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout_a[i] !== 32'h0 || vld_a[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: dout=%h valid=%b, want dout=00000000 valid=0",
                         i, dout_a[i], vld_a[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int a = 0; a < 1024; a++) begin
            fill_r[a] = $urandom;
            tick(1'b1, 4'hF, a[9:0], fill_r[a], 1'b0, 10'd0);
        end
        for (int a = 0; a < 1024; a++) begin
            tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, a[9:0]);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dout_a[i] !== fill_r[a] || vld_a[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL fill inst%0d addr %0d: dout=%h valid=%b, want %h valid=1",
                             i, a, dout_a[i], vld_a[i], fill_r[a]);
                end
            end
        end
    endtask

    task automatic test_byte_merge();
        tick(1'b1, 4'hF, 10'd5, 32'hAABBCCDD, 1'b0, 10'd0);
        tick(1'b1, 4'b0101, 10'd5, 32'h11223344, 1'b0, 10'd0);
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout_a[i] !== 32'hAA22CC44 || vld_a[i] !== 1'b1) begin
                errors++;
                $display("FAIL byte_merge inst%0d: dout=%h valid=%b, want AA22CC44 valid=1",
                         i, dout_a[i], vld_a[i]);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] exp_d [3];
        logic        exp_v [3];
        tick(1'b1, 4'hF, 10'd7, 32'h00000000, 1'b0, 10'd0);
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        tick(1'b1, 4'b0011, 10'd7, 32'hFFFFFFFF, 1'b1, 10'd7);
        exp_d[0] = 32'h00000000; exp_v[0] = 1'b1;
        exp_d[1] = 32'h0000FFFF; exp_v[1] = 1'b1;
        exp_d[2] = 32'hAA22CC44; exp_v[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout_a[i] !== exp_d[i] || vld_a[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL collision mode%0d: dout=%h valid=%b, want %h valid=%b",
                         i, dout_a[i], vld_a[i], exp_d[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_no_change_diff_addr();
        tick(1'b1, 4'hF, 10'd9, 32'h12345678, 1'b0, 10'd0);
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        tick(1'b1, 4'hF, 10'd3, 32'hDEADBEEF, 1'b1, 10'd9);
        checks++;
        if (dout2 !== 32'hAA22CC44 || vld2 !== 1'b0) begin
            errors++;
            $display("FAIL nc_diff_addr suppressed: dout=%h valid=%b, want AA22CC44 valid=0",
                     dout2, vld2);
        end
        checks++;
        if (dout0 !== 32'h12345678 || vld0 !== 1'b1) begin
            errors++;
            $display("FAIL rf_diff_addr: dout=%h valid=%b, want 12345678 valid=1", dout0, vld0);
        end
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd9);
        checks++;
        if (dout2 !== 32'h12345678 || vld2 !== 1'b1) begin
            errors++;
            $display("FAIL nc_diff_addr reread: dout=%h valid=%b, want 12345678 valid=1",
                     dout2, vld2);
        end
    endtask

    task automatic test_out_reg_stall();
        tick(1'b1, 4'hF, 10'd2, 32'hCAFEF00D, 1'b0, 10'd0);
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd2);
        checks++;
        if (vld3 !== 1'b0) begin
            errors++;
            $display("FAIL out_reg latency N: valid=%b, want 0", vld3);
        end
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
        checks++;
        if (dout3 !== 32'hCAFEF00D || vld3 !== 1'b1) begin
            errors++;
            $display("FAIL out_reg latency N+2: dout=%h valid=%b, want CAFEF00D valid=1",
                     dout3, vld3);
        end
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd2);
        for (int s = 0; s < 2; s++) begin
            tick(1'b0, 4'hF, 10'd2, 32'h0BAD0BAD, 1'b1, 10'd9);
            checks++;
            if (dout3 !== 32'hAA22CC44 || vld3 !== 1'b0 || dout2 !== 32'hCAFEF00D || vld2 !== 1'b1) begin
                errors++;
                $display("FAIL stall cycle %0d: or=%h/%b nc=%h/%b, want AA22CC44/0 CAFEF00D/1",
                         s, dout3, vld3, dout2, vld2);
            end
        end
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
        checks++;
        if (dout3 !== 32'hCAFEF00D || vld3 !== 1'b1) begin
            errors++;
            $display("FAIL stall release: dout=%h valid=%b, want CAFEF00D valid=1", dout3, vld3);
        end
    endtask

    task automatic test_reset_midflight();
        tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        #3;
        rst_n = 1'b0;
        ena = 1'b0; rd_en = 1'b0; we = 4'h0;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout_a[i] !== 32'h0 || vld_a[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset inst%0d: dout=%h valid=%b, want 00000000 valid=0",
                         i, dout_a[i], vld_a[i]);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (vld_a[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset inst%0d cycle %0d: valid=%b, want 0", i, c, vld_a[i]);
                end
            end
        end
    endtask

    task automatic test_random_mixed();
        logic [31:0] exp_d;
        logic        exp_v;
        for (int c = 0; c < 1024; c++) begin
            tick(($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                 10'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)));
            for (int i = 0; i < 4; i++) begin
                exp_d = (i == 3) ? m_s2d : m_s1d[i];
                exp_v = (i == 3) ? m_s2v : m_s1v[i];
                checks++;
                if (dout_a[i] !== exp_d || vld_a[i] !== exp_v) begin
                    errors++;
                    $display("FAIL random cycle %0d inst%0d: dout=%h valid=%b, want %h valid=%b",
                             c, i, dout_a[i], vld_a[i], exp_d, exp_v);
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) m_mem[a] = 32'h0;
        model_reset();
        test_reset();
        test_fill();
        test_byte_merge();
        test_collision();
        test_no_change_diff_addr();
        test_out_reg_stall();
        test_reset_midflight();
        test_random_mixed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bytewrite_sdp_ram_cfg.md
Name: bytewrite_sdp_ram_cfg

Overview:
Parametrised byte-write simple-dual-port RAM. One write port and one read port share a single clock, and each column is written under its own byte-enable. Read-during-write behaviour is selectable per instance, an optional output pipeline register can be enabled, and a read-valid flag travels alongside the data. The block is the next-generation drop-in for the fixed 4x8-bit no-change SDP RAM used in the co-simulation flows.

Parameters:
NUM_COL, 4, number of byte-enable columns
COL_WIDTH, 8, bits per column
ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH
RDW_MODE, 2, same-address read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1)
DATA_WIDTH, NUM_COL*COL_WIDTH, derived; must not be overridden

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
ena  input  1  global enable; when 0, no write, no read, and pipeline holds
we  input  NUM_COL  per-column write enable
write_addr  input  ADDR_WIDTH  write address
din  input  DATA_WIDTH  write data; column k = din[k*COL_WIDTH +: COL_WIDTH]
rd_en  input  1  read request
read_addr  input  ADDR_WIDTH  read address
dout  output  DATA_WIDTH  read data
dout_valid  output  1  dout holds data for a completed read this cycle

Behaviour:
- Reset: dout=0, dout_valid=0, stage-1 and stage-2 registers =0. Memory array is not reset; its contents are undefined until written.
- Reset is asynchronous assert and synchronous-safe deassert. Reset mid-read drops the in-flight read: no valid pulse appears after release.
- Write: on an edge with ena=1, for every k with we[k]=1, mem[write_addr] column k <= din column k. Other columns are unchanged.
- Read: on an edge with ena=1 and rd_en=1, stage-1 data <= mem[read_addr] and stage-1 valid <= 1.
- Read with ena=1 and rd_en=0: stage-1 valid <= 0 and stage-1 data holds.
- Latency: with OUT_REG=0, dout/dout_valid are stage 1 (1 cycle). With OUT_REG=1, stage 2 <= stage 1 when ena=1 (2 cycles).
- ena=0: all registers hold, including valid. This is a pipeline stall, not a flush.
- Same-address collision (ena=1, rd_en=1, |we=1, read_addr==write_addr):
  - READ_FIRST: returns the pre-write word.
  - WRITE_FIRST: per-column merge. Columns with we[k]=1 return din column k; the rest return the old stored column.
  - NO_CHANGE: any active write (any address) in the same cycle suppresses the read. Stage-1 data holds its previous value and stage-1 valid <= 0.
- Different-address read and write in the same cycle: the read returns stored data, except that NO_CHANGE still suppresses the read as above.
- Addresses wrap naturally at 2**ADDR_WIDTH; there are no out-of-range checks.
- Elaboration check: RDW_MODE > 2 or OUT_REG > 1 raises a fatal error.

Decomposition:
- Package bytewrite_ram_pkg holds localparams RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2, plus a function col_slice(k) that returns the bit offset.
- Sub-module bytewrite_ram_col holds one COL_WIDTH-wide column array with its own write enable, a read port, and same-address bypass logic. It is instantiated NUM_COL times in a generate loop.
- The top level owns the valid pipeline, the NO_CHANGE suppression, and the optional output register.

Test Plan:
1. Reset and fill (defaults, OUT_REG=0). Hold rst_n=0 for 3 cycles -> dout=0, dout_valid=0. Release, write addr 0..1023 with we=4'b1111 and din=$random, then read 0..1023 -> each dout matches the written word one cycle after rd_en, and dout_valid=1.
2. Byte merge. Write 0xAABBCCDD to addr 5, then write din=0x11223344 with we=4'b0101 -> a read of addr 5 returns 0xAA22CC44.
3. Collision in all three modes. Preload addr 7=0x00000000, then read and write addr 7 together with din=0xFFFFFFFF, we=4'b0011:
   - RDW_MODE=0 -> dout=0x00000000, valid=1.
   - RDW_MODE=1 -> dout=0x0000FFFF, valid=1.
   - RDW_MODE=2 -> dout holds the prior value, valid=0.
4. NO_CHANGE with different addresses. Write addr 3 while reading addr 9 (=0x12345678) -> valid=0 and dout unchanged. The next cycle's read of addr 9 (no write) -> dout=0x12345678, valid=1.
5. OUT_REG=1 and stall. Read addr 2 at cycle N -> dout valid at N+2. Drop ena for 2 cycles at N+1 -> dout and valid freeze, and the data emerges 2 cycles later than it otherwise would, unchanged.
6. Reset mid-flight. Issue a read, then assert rst_n=0 asynchronously between edges -> dout=0 and valid=0 immediately. After release, with no rd_en, valid stays 0. A random 1024-cycle mixed run then compared against a behavioural model gives 0 mismatches.
